seg7_scan_decoder: RTL and testbench

//   Reverse of the hex-to-7-segment encoder. Watches a multiplexed, active-low
//   7-segment display bus (segments plus anode enables) and recovers the hex

---
 rtl/seg7_scan_decoder.sv | 177 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed active-low 7-segment bus: recovers the hex
// nibble per digit, filters scan glitches, flags illegal patterns, expires stale digits.
module seg7_scan_decoder #(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 65536
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             seg,
  input  logic [NDIGITS-1:0]     an,
  output logic [4*NDIGITS-1:0]   digits,
  output logic [NDIGITS-1:0]     digit_valid,
  output logic                   update,
  output logic [2:0]             upd_idx,
  output logic                   err
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned BW = NDIGITS + 7;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t              state, state_n;
  logic [6:0]          seg_q;
  logic [NDIGITS-1:0]  an_q;
  logic [BW-1:0]       prev_q;
  logic [SW-1:0]       scnt;
  logic [NDIGITS-1:0]  sel_c;
  logic                onehot_c;
  logic                changed_c;
  logic                capture_c;
  logic [2:0]          idx_c;
  logic                cap_q;
  logic [2:0]          cap_idx;
  logic [6:0]          cap_pat;
  logic                legal_c;
  logic                blank_c;
  logic [3:0]          nib_c;
  logic [TW-1:0]       tcnt [NDIGITS];

  // Input stage plus one-cycle-old copy for change detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q  <= '0;
      an_q   <= '0;
      prev_q <= '0;
    end else begin
      seg_q  <= seg;
      an_q   <= an;
      prev_q <= {an_q, seg_q};
    end
  end

  assign changed_c = ({an_q, seg_q} != prev_q);
  assign sel_c     = ~an_q;
  assign onehot_c  = (sel_c != '0) && ((sel_c & (sel_c - NDIGITS'(1))) == '0);

  always_comb begin
    idx_c = 3'd0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (sel_c[i]) idx_c = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scnt <= '0;
    end else if (changed_c) begin
      scnt <= '0;
    end else if (scnt != SW'(SETTLE)) begin
      scnt <= scnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    capture_c = 1'b0;
    if (!onehot_c) begin
      state_n = S_IDLE;
    end else if (changed_c) begin
      state_n = S_SETTLE;
    end else begin
      case (state)
        S_IDLE:   state_n = S_SETTLE;
        S_SETTLE: begin
          if (scnt == SW'(SETTLE - 1)) begin
            state_n   = S_HOLD;
            capture_c = 1'b1;
          end
        end
        S_HOLD:   state_n = S_HOLD;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  // Capture is latched first, then committed to the outputs the following cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q   <= 1'b0;
      cap_idx <= '0;
      cap_pat <= '0;
    end else begin
      cap_q <= capture_c;
      if (capture_c) begin
        cap_idx <= idx_c;
        cap_pat <= ~seg_q;
      end
    end
  end

  always_comb begin
    legal_c = 1'b1;
    nib_c   = 4'h0;
    case (cap_pat)
      7'h7E: nib_c = 4'h0;
      7'h30: nib_c = 4'h1;
      7'h6D: nib_c = 4'h2;
      7'h79: nib_c = 4'h3;
      7'h33: nib_c = 4'h4;
      7'h5B: nib_c = 4'h5;
      7'h5F: nib_c = 4'h6;
      7'h70: nib_c = 4'h7;
      7'h7F: nib_c = 4'h8;
      7'h7B: nib_c = 4'h9;
      7'h77: nib_c = 4'hA;
      7'h1F: nib_c = 4'hB;
      7'h4E: nib_c = 4'hC;
      7'h3D: nib_c = 4'hD;
      7'h4F: nib_c = 4'hE;
      7'h47: nib_c = 4'hF;
      default: legal_c = 1'b0;
    endcase
  end

  assign blank_c = (cap_pat == 7'h00);

  // Output registers and per-digit staleness timers; a capture beats an expiry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      upd_idx     <= '0;
      err         <= 1'b0;
      for (int unsigned i = 0; i < NDIGITS; i++) tcnt[i] <= '0;
    end else begin
      update  <= cap_q;
      upd_idx <= cap_q ? cap_idx : 3'd0;
      err     <= cap_q && !legal_c && !blank_c;
      for (int unsigned i = 0; i < NDIGITS; i++) begin
        if (cap_q && (cap_idx == 3'(i))) begin
          tcnt[i]        <= '0;
          digit_valid[i] <= legal_c;
          if (legal_c) digits[4*i +: 4] <= nib_c;
        end else if (tcnt[i] != TMAX) begin
          tcnt[i] <= tcnt[i] + TW'(1);
        end else begin
          digit_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: run-length reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_seg7_scan_decoder;

  localparam int unsigned ND = 4;
  localparam int unsigned ST = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] digit_valid;
  logic          update;
  logic [2:0]    upd_idx;
  logic          err;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg7_scan_decoder #(.NDIGITS(ND), .SETTLE(ST), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .digits(digits),
    .digit_valid(digit_valid), .update(update), .upd_idx(upd_idx), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a capture commits SETTLE+2 edges after a new one-hot run
  // starts, provided that run lasted SETTLE+1 samples and no reset intervened.
  logic [11:0] hist [8];
  logic [3:0]  m_dig [ND];
  bit          m_leg [ND];
  int          m_tcap [ND];
  logic        m_upd, m_err;
  logic [2:0]  m_idx;
  logic [ND-1:0] m_valid;
  int          t = 0;

  initial begin
    bit run_ok;
    logic [3:0] sel;
    logic [6:0] p;
    int idx;
    int nib;
    for (int k = 0; k < 8; k++) hist[k] = 12'h800;
    m_upd = 1'b0; m_err = 1'b0; m_idx = '0; m_valid = '0;
    for (int i = 0; i < ND; i++) begin m_dig[i] = '0; m_leg[i] = 1'b0; m_tcap[i] = 0; end
    forever begin
      @(posedge clk);
      t++;
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = rst_n ? {1'b0, an, seg} : 12'h800;
      m_upd = 1'b0; m_err = 1'b0; m_idx = '0;
      if (!rst_n) begin
        for (int i = 0; i < ND; i++) begin m_dig[i] = '0; m_leg[i] = 1'b0; m_tcap[i] = 0; end
      end else begin
        run_ok = !hist[1][11] && !hist[6][11] && (hist[7] != hist[6]);
        for (int k = 2; k <= 5; k++) if (hist[k] != hist[6]) run_ok = 1'b0;
        sel = ~hist[6][10:7];
        if (run_ok && $countones(sel) == 1) begin
          idx = 0;
          for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
          p = ~hist[6][6:0];
          nib = -1;
          for (int k = 0; k < 16; k++) if (pat[k] == p) nib = k;
          m_upd = 1'b1;
          m_idx = 3'(idx);
          m_tcap[idx] = t;
          if (nib >= 0) begin
            m_dig[idx] = 4'(nib);
            m_leg[idx] = 1'b1;
          end else begin
            m_leg[idx] = 1'b0;
            m_err = (p != 7'h00);
          end
        end
      end
      for (int i = 0; i < ND; i++) m_valid[i] = m_leg[i] && ((t - m_tcap[i]) < TO);
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("m_update", 32'(update), 32'(m_upd));
        chk("m_err", 32'(err), 32'(m_err));
        chk("m_digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        chk("m_valid", 32'(digit_valid), 32'(m_valid));
        if (m_upd) chk("m_upd_idx", 32'(upd_idx), 32'(m_idx));
      end
    end
  end

  // Called on a negedge; returns on the negedge the capture becomes visible
  task automatic apply_expect(input logic [3:0] a, input logic [6:0] s, input int idx,
                              input logic [3:0] nib, input int kind);
    an = a;
    seg = s;
    repeat (6) @(negedge clk);
    chk("early_update", 32'(update), 32'd0);
    @(negedge clk);
    chk("update", 32'(update), 32'd1);
    chk("upd_idx", 32'(upd_idx), 32'(idx));
    chk("err", 32'(err), (kind == 1) ? 32'd1 : 32'd0);
    chk("nibble", 32'(digits[4*idx +: 4]), 32'(nib));
    chk("valid_bit", 32'(digit_valid[idx]), (kind == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    an  = 4'($urandom);
    seg = 7'($urandom);
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) begin
      an  = 4'($urandom);
      seg = 7'($urandom);
      @(negedge clk);
    end
    chk("rst_digits", 32'(digits), 32'd0);
    chk("rst_valid", 32'(digit_valid), 32'd0);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    an = 4'hF;
    seg = 7'h7F;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_update", 32'(update), 32'd0);
    chk("post_rst_valid", 32'(digit_valid), 32'd0);

    // Digit 0 showing '2'
    apply_expect(4'b1110, ~7'h6D, 0, 4'h2, 0);
    chk("t2_valid_vec", 32'(digit_valid), 32'b0001);
    @(negedge clk);

    // All patterns on all digits
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 16; k++) begin
        apply_expect(~(4'b0001 << d), ~pat[k], d, 4'(k), 0);
        @(negedge clk);
      end
    end

    // Glitch filter: too-short holds, then two anodes low
    seen = 1'b0;
    an = 4'b1110;
    for (int r = 0; r < 10; r++) begin
      seg = r[0] ? ~7'h30 : ~7'h6D;
      repeat (3) begin @(negedge clk); if (update) seen = 1'b1; end
    end
    chk("glitch_toggle", 32'(seen), 32'd0);
    seen = 1'b0;
    an = 4'b1100;
    seg = ~7'h7E;
    repeat (20) begin @(negedge clk); if (update) seen = 1'b1; end
    chk("glitch_two_low", 32'(seen), 32'd0);

    // Digit 2: legal '7', then illegal, then blank
    apply_expect(4'b1011, ~7'h70, 2, 4'h7, 0);
    @(negedge clk);
    apply_expect(4'b1011, ~7'h01, 2, 4'h7, 1);
    @(negedge clk);
    apply_expect(4'b1011, 7'h7F, 2, 4'h7, 2);
    @(negedge clk);

    // Timeout of digit 1 while only digit 0 is scanned
    apply_expect(4'b1101, ~7'h5B, 1, 4'h5, 0);
    an = 4'b1110;
    seg = ~7'h30;
    repeat (15) @(negedge clk);
    chk("to_valid_before", 32'(digit_valid[1]), 32'd1);
    @(negedge clk);
    chk("to_valid_after", 32'(digit_valid[1]), 32'd0);
    chk("to_digit_kept", 32'(digits[7:4]), 32'h5);

    // Reset during settling restarts the full latency
    an = 4'b0111;
    seg = ~7'h7B;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_update", 32'(update), 32'd0);
    chk("mid_rst_valid", 32'(digit_valid), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (update) seen = 1'b1; end
    chk("mid_rst_early", 32'(seen), 32'd0);
    @(negedge clk);
    chk("mid_rst_update_late", 32'(update), 32'd1);
    chk("mid_rst_digit", 32'(digits[15:12]), 32'h9);
    chk("mid_rst_valid_vec", 32'(digit_valid), 32'b1000);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
